mux_nto1_stream: RTL

- Parametrised successor to the fixed 8:1 1-bit gate-level selector used in the multiplier datapath.
- Selects one of CHANNELS input streams, each WIDTH bits wide, with a valid/ready handshake per channel.
- Two modes: fixed select, and round-robin arbitration.
- The chosen beat is captured into a registered output stage. Used to feed partial-product / operand streams into the sequential multiplier and the ALU result path.

---
 rtl/mux_pkg.sv | 33 +++
 rtl/mux_nto1_stream_rr_grant.sv | 30 +++
 rtl/mux_nto1_stream.sv | 98 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the stream selectors: mode encodings and the wrap-around
// first-set-bit scan used by round-robin arbiters.
package mux_pkg;

    localparam logic MODE_FIXED   = 1'b0;
    localparam logic MODE_RR      = 1'b1;
    localparam int   MAX_CHANNELS = 16;

    // Returns {found, index}: the first set bit of req[0..n-1] starting just after last.
    function automatic logic [4:0] first_set_wrap(
        input logic [MAX_CHANNELS-1:0] req,
        input logic [3:0]              last,
        input int                      n
    );
        logic       found;
        logic [3:0] idx;
        int         pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 1; k <= MAX_CHANNELS; k++) begin
            if (k <= n && !found) begin
                pos = (int'(last) + k) % n;
                if (req[pos]) begin
                    found = 1'b1;
                    idx   = 4'(pos);
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux_nto1_stream_rr_grant.sv
// Combinational round-robin grant: one-hot grant plus encoded index of the winner,
// searching from the channel after the last winner.
module rr_grant
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    idx
);

    logic [MAX_CHANNELS-1:0] req_pad;
    logic [3:0]              last_pad;
    logic [4:0]              scan;

    assign req_pad  = MAX_CHANNELS'(req);
    assign last_pad = 4'(last);
    assign scan     = first_set_wrap(req_pad, last_pad, CHANNELS);
    assign idx      = SEL_W'(scan[3:0]);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_grant
            assign grant[gi] = scan[4] && (scan[3:0] == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/mux_nto1_stream.sv
// N-to-1 valid/ready stream selector with fixed-select and round-robin modes,
// feeding a single registered output stage.
module mux_nto1_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    last_q, last_d;

    logic [CHANNELS-1:0] fixed_grant;
    logic [CHANNELS-1:0] rr_grant_vec;
    logic [SEL_W-1:0]    rr_idx;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                can_load;
    logic                xfer;

    // An out-of-range sel never matches any channel, so it yields no grant.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_fixed
            assign fixed_grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
        end
    endgenerate

    rr_grant #(.CHANNELS(CHANNELS)) u_rr_grant (
        .req   (in_valid),
        .last  (last_q),
        .grant (rr_grant_vec),
        .idx   (rr_idx)
    );

    assign grant     = (mode == MODE_RR) ? rr_grant_vec : fixed_grant;
    assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
    assign can_load  = !out_valid_q || out_ready;
    assign xfer      = (|grant) && can_load;
    assign in_ready  = grant & {CHANNELS{can_load && rst_n}};

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) last_d = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pointer resets to the top channel so channel 0 wins the first round-robin scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
